// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC sequencer: track/hold sampling, then one
// binary-search decision per clock driven to the capacitive DAC.
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adc_enable,
    input  logic             comp_in,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data
);

    localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB      = ONE << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sample_q, sample_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] decided;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            dac_q    <= '0;
            data_q   <= '0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dac_q    <= dac_d;
            data_q   <= data_d;
            sample_q <= sample_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Keep the trial bit only if the pixel is at or above the DAC level.
    assign decided = comp_in ? dac_q : (dac_q & ~(ONE << idx_q));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        dac_d    = dac_q;
        data_d   = data_q;
        sample_d = sample_q;
        done_d   = done_q;

        unique case (state_q)
            IDLE: begin
                done_d   = 1'b0;
                sample_d = 1'b0;
                dac_d    = '0;
                if (adc_enable) begin
                    state_d  = SAMPLE;
                    sample_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            SAMPLE: begin
                if (!adc_enable) begin
                    state_d  = IDLE;
                    sample_d = 1'b0;
                    dac_d    = '0;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = CONVERT;
                    sample_d = 1'b0;
                    dac_d    = MSB;
                    idx_d    = IDX_TOP;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CONVERT: begin
                if (!adc_enable) begin
                    state_d = IDLE;
                    dac_d   = '0;
                    idx_d   = '0;
                end else if (idx_q == '0) begin
                    state_d = DONE;
                    data_d  = decided;
                    dac_d   = decided;
                    done_d  = 1'b1;
                end else begin
                    dac_d = decided | (ONE << (idx_q - IDX_W'(1)));
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            DONE: begin
                if (!adc_enable) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    dac_d   = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                sample_d = 1'b0;
                done_d   = 1'b0;
                dac_d    = '0;
            end
        endcase

        busy_d = (state_d == SAMPLE) || (state_d == CONVERT);
    end

    assign sample   = sample_q;
    assign dac_code = dac_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign data     = data_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: ideal comparator against a binary-search
// reference, on a default 8-bit instance and a 10-bit/3-sample instance.
module tb_sar_adc_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       en_a = 1'b0;
    logic [7:0] vin_a = '0;
    logic       sample_a, busy_a, done_a, comp_a;
    logic [7:0] dac_a, data_a;

    logic       en_b = 1'b0;
    logic [9:0] vin_b = '0;
    logic       sample_b, busy_b, done_b, comp_b;
    logic [9:0] dac_b, data_b;

    assign comp_a = (vin_a >= dac_a);
    assign comp_b = (vin_b >= dac_b);

    sar_adc_ctrl dut_a (
        .clk(clk), .reset(reset), .adc_enable(en_a), .comp_in(comp_a),
        .sample(sample_a), .dac_code(dac_a), .busy(busy_a),
        .done(done_a), .data(data_a)
    );

    sar_adc_ctrl #(.WIDTH(10), .SAMPLE_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .adc_enable(en_b), .comp_in(comp_b),
        .sample(sample_b), .dac_code(dac_b), .busy(busy_b),
        .done(done_b), .data(data_b)
    );

    int n_chk = 0;
    int n_fail = 0;
    int last_res[2] = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_en(input int sel, input logic v);
        if (sel != 0) en_b = v;
        else en_a = v;
    endtask

    task automatic obs(input int sel, output logic s, output logic b,
                       output logic d, output logic [31:0] dac,
                       output logic [31:0] dat);
        if (sel != 0) begin
            s = sample_b; b = busy_b; d = done_b;
            dac = 32'(dac_b); dat = 32'(data_b);
        end else begin
            s = sample_a; b = busy_a; d = done_a;
            dac = 32'(dac_a); dat = 32'(data_a);
        end
    endtask

    // Full conversion; hold = extra cycles enable stays high after done.
    task automatic conv(input int sel, input int v, input int hold,
                        input string tag);
        int w = (sel != 0) ? 10 : 8;
        int sc = (sel != 0) ? 3 : 2;
        int code = 0;
        int trial[$];
        logic s, b, d;
        logic [31:0] dac, dat;
        for (int k = w - 1; k >= 0; k--) begin
            trial.push_back(code + (1 << k));
            if (v >= code + (1 << k)) code += (1 << k);
        end
        if (sel != 0) vin_b = v[9:0];
        else vin_a = v[7:0];
        set_en(sel, 1'b1);
        for (int e = 0; e <= sc + w; e++) begin
            @(negedge clk);
            obs(sel, s, b, d, dac, dat);
            if (e < sc) begin
                chk({tag, ".smp_hi"}, 32'(s), 32'd1);
                chk({tag, ".busy"}, 32'(b), 32'd1);
                chk({tag, ".done0"}, 32'(d), 32'd0);
                chk({tag, ".data_keep"}, dat, 32'(last_res[sel]));
            end else if (e < sc + w) begin
                chk({tag, ".smp_lo"}, 32'(s), 32'd0);
                chk({tag, ".trial"}, dac, 32'(trial[e - sc]));
                chk({tag, ".done0"}, 32'(d), 32'd0);
                chk({tag, ".data_keep"}, dat, 32'(last_res[sel]));
            end else begin
                chk({tag, ".done1"}, 32'(d), 32'd1);
                chk({tag, ".data"}, dat, 32'(code));
                chk({tag, ".dac_fin"}, dac, 32'(code));
                chk({tag, ".busy0"}, 32'(b), 32'd0);
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            obs(sel, s, b, d, dac, dat);
            chk({tag, ".hold_done"}, 32'(d), 32'd1);
            chk({tag, ".hold_data"}, dat, 32'(code));
        end
        last_res[sel] = code;
        set_en(sel, 1'b0);
        @(negedge clk);
        obs(sel, s, b, d, dac, dat);
        chk({tag, ".drop_done"}, 32'(d), 32'd0);
        chk({tag, ".idle_dac"}, dac, 32'd0);
        chk({tag, ".idle_data"}, dat, 32'(code));
    endtask

    task automatic chk_zero(input int sel, input string tag);
        logic s, b, d;
        logic [31:0] dac, dat;
        obs(sel, s, b, d, dac, dat);
        chk({tag, ".sample"}, 32'(s), 32'd0);
        chk({tag, ".busy"}, 32'(b), 32'd0);
        chk({tag, ".done"}, 32'(d), 32'd0);
        chk({tag, ".dac"}, dac, 32'd0);
        chk({tag, ".data"}, dat, 32'd0);
    endtask

    initial begin
        logic s, b, d;
        logic [31:0] dac, dat;

        #12;
        chk_zero(0, "rst_a");
        chk_zero(1, "rst_b");
        @(negedge clk);
        reset = 1'b0;

        conv(0, 'hA5, 0, "a5");
        conv(0, 'h00, 0, "zero");
        conv(0, 'hFF, 0, "ones");
        conv(0, 'hA5, 5, "hold");
        conv(0, 'h3C, 0, "re3c");
        conv(0, 'hA5, 0, "pre_abort");

        // Abort after the fourth CONVERT trial is on the DAC.
        vin_a = 8'h5A;
        en_a = 1'b1;
        repeat (6) @(negedge clk);
        en_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            obs(0, s, b, d, dac, dat);
            chk("abort.done", 32'(d), 32'd0);
            chk("abort.dac", dac, 32'd0);
            chk("abort.data", dat, 32'hA5);
            chk("abort.busy", 32'(b), 32'd0);
            chk("abort.sample", 32'(s), 32'd0);
        end

        // Asynchronous reset in the middle of CONVERT.
        vin_a = 8'h5A;
        en_a = 1'b1;
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_zero(0, "arst_a");
        chk_zero(1, "arst_b");
        last_res = '{0, 0};
        en_a = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        conv(0, 'h81, 0, "post_rst");

        repeat (4) conv(0, int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 2)), "rnd8");

        conv(1, 'h000, 0, "b_zero");
        conv(1, 'h3FF, 0, "b_ones");
        repeat (4) conv(1, int'($urandom_range(0, 1023)), 0, "b2b");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_adc_ctrl.md
SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, ADC resolution in bits (legal range 2..16).
REQ-002 SHALL have parameter SAMPLE_CYCLES, default 2, track/hold sampling duration in clk cycles (legal range >=1).
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port adc_enable  input  1  conversion request from the pixel row sequencer; held high until done is observed.
REQ-006 SHALL have port comp_in  input  1  comparator result; 1 means pixel voltage >= DAC voltage for the current dac_code.
REQ-007 SHALL have port sample  output  1  track/hold switch control; 1 means tracking.
REQ-008 SHALL have port dac_code  output  WIDTH  trial code driven to the capacitive DAC.
REQ-009 SHALL have port busy  output  1  high in SAMPLE and CONVERT states.
REQ-010 SHALL have port done  output  1  conversion complete; returned to the sequencer.
REQ-011 SHALL have port data  output  WIDTH  last completed conversion result.

Function
REQ-012 SHALL implement states IDLE, SAMPLE, CONVERT, DONE; all outputs registered.
REQ-013 IDLE: adc_enable=1 at an edge -> SAMPLE, sample<=1, sample counter<=0; otherwise stay in IDLE, done=0, sample=0.
REQ-014 SAMPLE: counter increments each edge; at the edge where counter==SAMPLE_CYCLES-1 -> CONVERT, sample<=0, dac_code<=1<<(WIDTH-1), bit index<=WIDTH-1; sample is therefore high for exactly SAMPLE_CYCLES cycles.
REQ-015 CONVERT, per edge: decided = comp_in ? dac_code : dac_code with bit[index] cleared; comp_in is sampled while dac_code holds the trial value (DAC and comparator settle within one cycle).
REQ-016 CONVERT with index>0: dac_code<=decided with bit[index-1] set, index<=index-1.
REQ-017 CONVERT with index==0: data<=decided, dac_code<=decided, done<=1 -> DONE; CONVERT therefore lasts exactly WIDTH cycles.
REQ-018 Latency: done is high SAMPLE_CYCLES+WIDTH cycles after the edge that samples adc_enable=1 in IDLE (10 cycles with defaults).
REQ-019 DONE: done held at 1 and data stable while adc_enable=1; no new conversion starts in DONE.
REQ-020 DONE with adc_enable=0 at an edge -> IDLE, done<=0; a new conversion requires adc_enable sampled high in IDLE.
REQ-021 Abort: adc_enable=0 at any edge in SAMPLE or CONVERT -> IDLE, sample<=0, dac_code<=0; done is not asserted and data retains its previous value.
REQ-022 data SHALL change only on the REQ-017 edge; dac_code is 0 in IDLE.
REQ-023 Boundary cases: comp_in constantly 1 yields all-ones; comp_in constantly 0 yields zero; no arithmetic overflow is possible because only bit set/clear is used.

Reset
REQ-024 While reset=1, regardless of clk: state=IDLE, sample=0, dac_code=0, busy=0, done=0, data=0, counters=0.
REQ-025 Reset mid-SAMPLE or mid-CONVERT SHALL abandon the conversion with no done pulse; the first edge after release with adc_enable=1 starts a fresh SAMPLE.

Verification
REQ-026 Bench comparator model comp_in=(vin>=dac_code) with vin=0xA5 and enable held -> dac_code trace 80,C0,A0,B0,A8,A4,A6,A5; data=0xA5; done high 10 cycles after the enable edge.
REQ-027 vin=0x00 -> data=0x00; vin=0xFF -> data=0xFF; both with done at cycle 10 and sample high for exactly 2 cycles.
REQ-028 Hold adc_enable for 5 cycles after done -> done stays 1 and data stays stable; drop enable -> done=0 the next cycle; re-raise enable -> new conversion, vin=0x3C -> data=0x3C.
REQ-029 Drop adc_enable at CONVERT cycle 4 after a prior result of 0xA5 -> IDLE, no done, data stays 0xA5, dac_code=0.
REQ-030 Assert reset asynchronously mid-CONVERT -> all outputs 0 immediately; after release, a full conversion of vin=0x81 -> data=0x81.
REQ-031 Run 4 back-to-back conversions with sequencer-style handshake (enable drops the cycle after done) and WIDTH=10, SAMPLE_CYCLES=3 -> each done at cycle 13 and data equal to each vin.
